// File: rtl/blink_shift_ctrl_if.sv
// Control and LED-status bundle for blink_shift_ctrl.
// The master drives enable/select/mode and the slave (the pattern engine) returns the outputs.
interface blink_shift_ctrl_if #(
    parameter int unsigned N_LEDS = 4
);
    logic              i_enable;
    logic [1:0]        i_sel;
    logic [1:0]        i_mode;
    logic              o_tick;
    logic [N_LEDS-1:0] o_led;
    logic              o_dir;

    modport master (
        output i_enable, i_sel, i_mode,
        input  o_tick, o_led, o_dir
    );

    modport slave (
        input  i_enable, i_sel, i_mode,
        output o_tick, o_led, o_dir
    );
endinterface

// File: rtl/blink_shift_ctrl.sv
// LED pattern engine: a prescaler with a runtime-selected period steps an N_LEDS-wide pattern
// through one of four modes: rotate-left, rotate-right, ping-pong or blink-all.
module blink_shift_ctrl #(
    parameter int unsigned N_LEDS  = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned PERIOD0 = 10,
    parameter int unsigned PERIOD1 = 5,
    parameter int unsigned PERIOD2 = 3,
    parameter int unsigned PERIOD3 = 2
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    blink_shift_ctrl_if.slave    if_bus
);
    typedef enum logic [1:0] {ModeRotL = 2'b00, ModeRotR = 2'b01,
                              ModePing = 2'b10, ModeBlink = 2'b11} mode_e;

    logic [CNT_W-1:0]  r_cnt;
    logic              r_tick;
    logic [N_LEDS-1:0] r_led;
    logic              r_dir;
    mode_e             r_mode;

    logic [CNT_W-1:0]  w_pm1;
    logic              w_wrap;
    logic              w_mode_chg;
    logic [N_LEDS-1:0] w_led_nxt;
    logic              w_dir_nxt;

    always_comb begin
        w_pm1 = CNT_W'(PERIOD0 - 1);
        unique case (if_bus.i_sel)
            2'd0: w_pm1 = CNT_W'(PERIOD0 - 1);
            2'd1: w_pm1 = CNT_W'(PERIOD1 - 1);
            2'd2: w_pm1 = CNT_W'(PERIOD2 - 1);
            2'd3: w_pm1 = CNT_W'(PERIOD3 - 1);
            default: w_pm1 = CNT_W'(PERIOD0 - 1);
        endcase
    end

    // ">=" lets a shortened period wrap on the next enabled cycle instead of overrunning.
    assign w_wrap     = if_bus.i_enable && (r_cnt >= w_pm1);
    assign w_mode_chg = (mode_e'(if_bus.i_mode) != r_mode);

    always_comb begin
        w_led_nxt = r_led;
        w_dir_nxt = r_dir;
        unique case (r_mode)
            ModeRotL: for (int i = 0; i < int'(N_LEDS); i++)
                          w_led_nxt[i] = r_led[(i + int'(N_LEDS) - 1) % int'(N_LEDS)];
            ModeRotR: for (int i = 0; i < int'(N_LEDS); i++)
                          w_led_nxt[i] = r_led[(i + 1) % int'(N_LEDS)];
            ModePing: begin
                // A single LED has nowhere to bounce, so ping-pong holds.
                if (N_LEDS > 1) begin
                    if (!r_dir && r_led[N_LEDS-1]) begin
                        w_dir_nxt = 1'b1;
                        w_led_nxt = r_led >> 1;
                    end else if (r_dir && r_led[0]) begin
                        w_dir_nxt = 1'b0;
                        w_led_nxt = r_led << 1;
                    end else if (r_dir) begin
                        w_led_nxt = r_led >> 1;
                    end else begin
                        w_led_nxt = r_led << 1;
                    end
                end
            end
            ModeBlink: w_led_nxt = ~r_led;
            default:   w_led_nxt = r_led;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
            r_led  <= N_LEDS'(1);
            r_dir  <= 1'b0;
            r_mode <= ModeRotL;
        end else begin
            if (if_bus.i_enable) begin
                r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
                r_tick <= w_wrap;
            end else begin
                r_tick <= 1'b0;
            end
            // A mode change reloads the pattern and beats a coincident tick step.
            if (w_mode_chg) begin
                r_led  <= N_LEDS'(1);
                r_dir  <= 1'b0;
                r_mode <= mode_e'(if_bus.i_mode);
            end else if (w_wrap) begin
                r_led  <= w_led_nxt;
                r_dir  <= w_dir_nxt;
            end
        end
    end

    assign if_bus.o_tick = r_tick;
    assign if_bus.o_led  = r_led;
    assign if_bus.o_dir  = r_dir;
endmodule

// File: tb/tb_blink_shift_ctrl.sv
// Self-checking bench for blink_shift_ctrl: directed scenarios plus a randomized run,
// all compared against a position/arithmetic reference model.
module tb_blink_shift_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    blink_shift_ctrl_if #(.N_LEDS(4)) bus ();

    blink_shift_ctrl #(
        .N_LEDS(4), .CNT_W(32), .PERIOD0(10), .PERIOD1(5), .PERIOD2(3), .PERIOD3(2)
    ) dut (
        .clk    (clk),
        .i_rst_n(rst_n),
        .if_bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int per [4]  = '{10, 5, 3, 2};

    // Reference model state.
    int       m_cnt;
    logic     m_tick;
    logic [3:0] m_led;
    logic     m_dir;
    logic [1:0] m_mode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_cnt = 0; m_tick = 0; m_led = 4'b0001; m_dir = 0; m_mode = 0;
    endfunction

    function automatic int led_pos(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic void model_edge(input logic en, input logic [1:0] sel,
                                       input logic [1:0] mode);
        logic wrap;
        int   pos;
        wrap = en && (m_cnt >= per[sel] - 1);
        if (en) begin
            m_cnt  = wrap ? 0 : m_cnt + 1;
            m_tick = wrap;
        end else begin
            m_tick = 0;
        end
        if (mode != m_mode) begin
            m_led = 4'b0001; m_dir = 0; m_mode = mode;
        end else if (wrap) begin
            case (m_mode)
                2'd0: m_led = 4'((m_led * 2) % 16 + m_led / 8);
                2'd1: m_led = 4'(m_led / 2 + (m_led % 2) * 8);
                2'd2: begin
                    pos = led_pos(m_led);
                    if (!m_dir) begin
                        if (pos == 3) begin m_dir = 1; pos = 2; end else pos++;
                    end else begin
                        if (pos == 0) begin m_dir = 0; pos = 1; end else pos--;
                    end
                    m_led = 4'(1 << pos);
                end
                default: m_led = 4'(15 - m_led);
            endcase
        end
    endfunction

    task automatic step();
        model_edge(bus.i_enable, bus.i_sel, bus.i_mode);
        @(posedge clk);
        #1;
        chk("tick", 32'(bus.o_tick), 32'(m_tick));
        chk("led",  32'(bus.o_led),  32'(m_led));
        chk("dir",  32'(bus.o_dir),  32'(m_dir));
    endtask

    task automatic run_to_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.o_tick && n < 50);
        if (!bus.o_tick) chk("tick_timeout", 32'(bus.o_tick), 32'd1);
    endtask

    task automatic run_to_cnt(input int k);
        for (int i = 0; i < 50 && m_cnt != k; i++) step();
    endtask

    logic [3:0] exp_rl [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_pp [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                               4'b0010, 4'b0001, 4'b0010, 4'b0100};
    logic       exp_pd [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int n;
        int first;
        logic [3:0] led_hold;

        // Reset held with clock running.
        rst_n = 0;
        bus.i_enable = 0; bus.i_sel = 0; bus.i_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led",  32'(bus.o_led),  32'h1);
        chk("rst_tick", 32'(bus.o_tick), 32'h0);
        chk("rst_dir",  32'(bus.o_dir),  32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // First tick after P=10 enabled cycles, then every 10.
        bus.i_enable = 1;
        run_to_tick(first);
        chk("first_tick_latency", 32'(first), 32'd10);
        run_to_tick(n);
        chk("second_tick_latency", 32'(n), 32'd10);

        // Rotate-left from a fresh reload.
        bus.i_sel = 3;
        bus.i_mode = 1; step();
        bus.i_mode = 0; step();
        chk("reload_led", 32'(bus.o_led), 32'h1);
        for (int i = 0; i < 4; i++) begin
            run_to_tick(n);
            chk("rotl_seq", 32'(bus.o_led), 32'(exp_rl[i]));
        end
        bus.i_mode = 1; step();
        chk("rotr_reload", 32'(bus.o_led), 32'h1);
        run_to_tick(n);
        chk("rotr_seq0", 32'(bus.o_led), 32'h8);
        run_to_tick(n);
        chk("rotr_seq1", 32'(bus.o_led), 32'h4);

        // Ping-pong bounce.
        bus.i_mode = 2; step();
        for (int i = 0; i < 8; i++) begin
            run_to_tick(n);
            chk("pp_led", 32'(bus.o_led), 32'(exp_pp[i]));
            chk("pp_dir", 32'(bus.o_dir), 32'(exp_pd[i]));
        end

        // Enable freeze, then period shortening mid-count.
        bus.i_sel = 0;
        run_to_cnt(7);
        led_hold = bus.o_led;
        bus.i_enable = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("frozen_tick", 32'(bus.o_tick), 32'd0);
            chk("frozen_led",  32'(bus.o_led),  32'(led_hold));
        end
        bus.i_enable = 1;
        run_to_tick(n);
        chk("resume_latency", 32'(n), 32'd3);
        run_to_cnt(7);
        bus.i_sel = 2;
        step();
        chk("shorten_wrap", 32'(bus.o_tick), 32'd1);

        // Blink, then a mode change coinciding with a tick.
        bus.i_mode = 3; step();
        run_to_tick(n);
        chk("blink0", 32'(bus.o_led), 32'hE);
        chk("blink_period", 32'(n) <= 32'd3 ? 32'd1 : 32'd0, 32'd1);
        run_to_tick(n);
        chk("blink1", 32'(bus.o_led), 32'h1);
        chk("blink_period3", 32'(n), 32'd3);
        run_to_cnt(2);
        bus.i_mode = 0;
        step();
        chk("chg_on_tick_tick", 32'(bus.o_tick), 32'd1);
        chk("chg_on_tick_led",  32'(bus.o_led),  32'h1);

        // Randomized run.
        for (int i = 0; i < 400; i++) begin
            bus.i_enable = ($urandom_range(7) != 0);
            if ($urandom_range(9) == 0) bus.i_sel = 2'($urandom_range(3));
            if ($urandom_range(15) == 0) bus.i_mode = 2'($urandom_range(3));
            step();
        end

        // Asynchronous reset mid ping-pong, between clock edges.
        bus.i_enable = 1; bus.i_sel = 3; bus.i_mode = 2;
        for (int i = 0; i < 9; i++) step();
        #2;
        rst_n = 0;
        #1;
        chk("async_led",  32'(bus.o_led),  32'h1);
        chk("async_tick", 32'(bus.o_tick), 32'h0);
        chk("async_dir",  32'(bus.o_dir),  32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 12; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
